// File: rtl/pbkdf2_iter_ctrl_if.sv
// ---------------------------------------------------------------------------
// pbkdf2_iter_ctrl_if
//
// Request/response link between the PBKDF2 iteration controller and the
// single HMAC-SHA256 core it drives. The _o/_i suffixes are named from the
// controller's side of the link.
//
//   h_key_o  [511:0]  HMAC key (latched password)
//   h_msg_o  [511:0]  HMAC message, left-aligned
//   h_len_o  [5:0]    message length in bytes
//   h_v_o / h_r_i     request handshake  (controller -> core)
//   h_prf_i  [255:0]  HMAC result
//   h_v_i / h_r_o     result handshake   (core -> controller)
//
// Modports: master = iteration controller, slave = HMAC core.
// ---------------------------------------------------------------------------
interface pbkdf2_iter_ctrl_if;
    logic [511:0] h_key_o;
    logic [511:0] h_msg_o;
    logic [5:0]   h_len_o;
    logic         h_v_o;
    logic         h_r_i;
    logic [255:0] h_prf_i;
    logic         h_v_i;
    logic         h_r_o;

    modport master (
        output h_key_o, h_msg_o, h_len_o, h_v_o, h_r_o,
        input  h_r_i, h_prf_i, h_v_i
    );

    modport slave (
        input  h_key_o, h_msg_o, h_len_o, h_v_o, h_r_o,
        output h_r_i, h_prf_i, h_v_i
    );
endinterface

// File: rtl/pbkdf2_iter_ctrl.sv
// ---------------------------------------------------------------------------
// pbkdf2_iter_ctrl
//
// Runs PBKDF2-HMAC-SHA256 for one 256-bit derived-key block by repeatedly
// driving one HMAC core: U1 = HMAC(P, S || INT(idx)), Uj = HMAC(P, Uj-1),
// T = U1 ^ U2 ^ ... ^ Uc.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   pwd_i   [511:0]     password, left-aligned, zero-filled
//   salt_i  [407:0]     salt, left-aligned (max 51 bytes)
//   salt_len_i [5:0]    salt length in bytes
//   iter_i  [ITER_W-1:0] iteration count c
//   v_i / r_o           host request handshake
//   dk_o    [255:0]     derived-key block T
//   err_o               request was rejected (dk_o = 0)
//   v_o / r_i           result handshake
//   h                   HMAC core link (pbkdf2_iter_ctrl_if.master)
//
// Optional feature macro PBKDF2_BLKIDX_EN: adds blk_idx_i [31:0], sampled on
// accept and used as the block index in U1 (zero is rejected). Without it
// the block index is fixed at 1.
// ---------------------------------------------------------------------------
module pbkdf2_iter_ctrl #(
    parameter int unsigned ITER_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [511:0]      pwd_i,
    input  logic [407:0]      salt_i,
    input  logic [5:0]        salt_len_i,
    input  logic [ITER_W-1:0] iter_i,
`ifdef PBKDF2_BLKIDX_EN
    input  logic [31:0]       blk_idx_i,
`endif
    input  logic              v_i,
    output logic              r_o,
    output logic [255:0]      dk_o,
    output logic              err_o,
    output logic              v_o,
    input  logic              r_i,
    pbkdf2_iter_ctrl_if.master h
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [5:0]   SALT_MAX  = 6'd51;
    localparam logic [407:0] SALT_ONES = '1;

    logic [1:0]        state_q, state_d;
    logic [511:0]      pwd_q,   pwd_d;
    logic [407:0]      salt_q,  salt_d;
    logic [5:0]        slen_q,  slen_d;
    logic [ITER_W-1:0] cnt_q,   cnt_d;
    logic              first_q, first_d;
    logic [255:0]      u_q,     u_d;
    logic [255:0]      t_q,     t_d;
    logic              err_q,   err_d;

    logic              idx_bad;
    logic [31:0]       idx_use;

`ifdef PBKDF2_BLKIDX_EN
    logic [31:0]       idx_q, idx_d;
    assign idx_bad = (blk_idx_i == '0);
    assign idx_use = idx_q;
`else
    assign idx_bad = 1'b0;
    assign idx_use = 32'd1;
`endif

    // Request screening and salt clean-up happen on the accept cycle.
    logic         reject;
    logic [407:0] salt_mask;

    assign reject    = (iter_i == '0) || (salt_len_i > SALT_MAX) || idx_bad;
    // Keep only the top salt_len bytes so stray host bits never reach U1.
    assign salt_mask = ~(SALT_ONES >> {salt_len_i, 3'b000});

    // U1 message: salt bytes followed immediately by the 32-bit index.
    logic [511:0] idx_field;
    logic [511:0] msg_first;
    logic [511:0] msg_next;

    assign idx_field = {idx_use, 480'b0} >> {slen_q, 3'b000};
    assign msg_first = {salt_q, 104'b0} | idx_field;
    assign msg_next  = {u_q, 256'b0};

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pwd_d   = pwd_q;
        salt_d  = salt_q;
        slen_d  = slen_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        u_d     = u_q;
        t_d     = t_q;
        err_d   = err_q;
`ifdef PBKDF2_BLKIDX_EN
        idx_d   = idx_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (v_i) begin
                    pwd_d  = pwd_i;
                    salt_d = salt_i & salt_mask;
                    slen_d = salt_len_i;
                    cnt_d  = iter_i;
`ifdef PBKDF2_BLKIDX_EN
                    idx_d  = blk_idx_i;
`endif
                    // T is cleared here so a rejected request reports dk = 0.
                    t_d    = '0;
                    u_d    = '0;
                    if (reject) begin
                        err_d   = 1'b1;
                        first_d = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        first_d = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                if (h.h_r_i) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (h.h_v_i) begin
                    u_d     = h.h_prf_i;
                    t_d     = first_q ? h.h_prf_i : (t_q ^ h.h_prf_i);
                    first_d = 1'b0;
                    cnt_d   = cnt_q - ITER_W'(1);
                    state_d = (cnt_q == ITER_W'(1)) ? S_DONE : S_ISSUE;
                end
            end

            S_DONE: begin
                if (r_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pwd_q   <= '0;
            salt_q  <= '0;
            slen_q  <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            u_q     <= '0;
            t_q     <= '0;
            err_q   <= 1'b0;
`ifdef PBKDF2_BLKIDX_EN
            idx_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pwd_q   <= pwd_d;
            salt_q  <= salt_d;
            slen_q  <= slen_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            u_q     <= u_d;
            t_q     <= t_d;
            err_q   <= err_d;
`ifdef PBKDF2_BLKIDX_EN
            idx_q   <= idx_d;
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: decoded from registered state only. rst_i gates them so the
    // whole interface reads 0 while reset is held (IDLE alone would raise r_o).
    // ---------------------------------------------------------------------
    logic live;
    assign live = ~rst_i;

    assign r_o   = live && (state_q == S_IDLE);
    assign v_o   = live && (state_q == S_DONE);
    assign dk_o  = live ? t_q : '0;
    assign err_o = live && err_q;

    assign h.h_v_o   = live && (state_q == S_ISSUE);
    assign h.h_r_o   = live && (state_q == S_WAIT);
    assign h.h_key_o = live ? pwd_q : '0;
    assign h.h_msg_o = live ? (first_q ? msg_first : msg_next) : '0;
    assign h.h_len_o = live ? (first_q ? (slen_q + 6'd4) : 6'd32) : '0;

endmodule

// File: tb/tb_pbkdf2_iter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pbkdf2_iter_ctrl
//
// Directed bench for pbkdf2_iter_ctrl with a behavioural HMAC-SHA256 core
// on the slave side of the link. Expected derived keys are the published
// PBKDF2-HMAC-SHA256 vectors for P="password", S="salt".
// ---------------------------------------------------------------------------
module tb_pbkdf2_iter_ctrl;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [511:0] pwd_i;
    logic [407:0] salt_i;
    logic [5:0]   salt_len_i;
    logic [31:0]  iter_i;
    logic         v_i;
    logic         r_o;
    logic [255:0] dk_o;
    logic         err_o;
    logic         v_o;
    logic         r_i;
`ifdef PBKDF2_BLKIDX_EN
    logic [31:0]  blk_idx_i = 32'd1;
`endif

    pbkdf2_iter_ctrl_if hbus ();

    pbkdf2_iter_ctrl #(.ITER_W(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .pwd_i      (pwd_i),
        .salt_i     (salt_i),
        .salt_len_i (salt_len_i),
        .iter_i     (iter_i),
`ifdef PBKDF2_BLKIDX_EN
        .blk_idx_i  (blk_idx_i),
`endif
        .v_i        (v_i),
        .r_o        (r_o),
        .dk_o       (dk_o),
        .err_o      (err_o),
        .v_o        (v_o),
        .r_i        (r_i),
        .h          (hbus)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Constants
    // ---------------------------------------------------------------------
    localparam logic [511:0] PWD       = {64'h70617373776f7264, 448'b0};
    localparam logic [407:0] SALT4     = {32'h73616c74, 376'b0};
    localparam logic [407:0] SALT4_JNK = {32'h73616c74, {47{8'hA5}}};
    localparam logic [407:0] SALT51    = {51{8'h5a}};
    localparam logic [511:0] MSG1      = {32'h73616c74, 32'h00000001, 448'b0};
    localparam logic [511:0] MSG51     = {{51{8'h5a}}, 32'h00000001, 72'b0};
    localparam logic [255:0] DK1    = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
    localparam logic [255:0] DK2    = 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;
    localparam logic [255:0] DK4096 = 256'hc5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a;
    localparam logic [255:0] SHA_H0 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    logic [31:0] sha_k [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // ---------------------------------------------------------------------
    // Bookkeeping
    // ---------------------------------------------------------------------
    int unsigned  n_cmp = 0;
    int unsigned  n_bad = 0;
    int unsigned  nreq  = 0;
    int unsigned  lat_fix = 0;
    bit           stall_en = 1'b0;
    logic [511:0] msg_log [0:1];
    logic [5:0]   len_log [0:1];

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference SHA-256 / HMAC-SHA256
    // ---------------------------------------------------------------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_blk(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] wa, wb, wc, wd, we, wf, wg, wh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {wa, wb, wc, wd, we, wf, wg, wh} = hin;
        for (int i = 0; i < 64; i++) begin
            s1 = ror(we, 6) ^ ror(we, 11) ^ ror(we, 25);
            t1 = wh + s1 + ((we & wf) ^ (~we & wg)) + sha_k[i] + w[i];
            s0 = ror(wa, 2) ^ ror(wa, 13) ^ ror(wa, 22);
            t2 = s0 + ((wa & wb) ^ (wa & wc) ^ (wb & wc));
            wh = wg; wg = wf; wf = we; we = wd + t1;
            wd = wc; wc = wb; wb = wa; wa = t1 + t2;
        end
        return {hin[255:224] + wa, hin[223:192] + wb, hin[191:160] + wc, hin[159:128] + wd,
                hin[127:96]  + we, hin[95:64]   + wf, hin[63:32]   + wg, hin[31:0]    + wh};
    endfunction

    function automatic logic [255:0] hmac_ref(input logic [511:0] key, input logic [511:0] msg,
                                              input logic [5:0] len);
        logic [511:0] ones, top, blk;
        logic [255:0] ih;
        ones = '1;
        top  = {8'h80, 504'b0};
        blk  = (msg & ~(ones >> (int'(len) * 8))) | (top >> (int'(len) * 8));
        blk[63:0] = 64'(512 + int'(len) * 8);
        ih  = sha_blk(sha_blk(SHA_H0, key ^ {64{8'h36}}), blk);
        blk = {ih, 8'h80, 184'b0, 64'd768};
        return sha_blk(sha_blk(SHA_H0, key ^ {64{8'h5c}}), blk);
    endfunction

    // ---------------------------------------------------------------------
    // Behavioural HMAC core (slave side), acting on negedges
    // ---------------------------------------------------------------------
    initial begin : hmac_model
        logic [511:0] k, m;
        logic [5:0]   l;
        logic [255:0] p;
        int unsigned  d;
        bit           ab;
        hbus.h_r_i   = 1'b0;
        hbus.h_v_i   = 1'b0;
        hbus.h_prf_i = '0;
        @(negedge clk);
        forever begin
            if (rst_i || !hbus.h_v_o) begin
                @(negedge clk);
                continue;
            end
            k = hbus.h_key_o;
            m = hbus.h_msg_o;
            l = hbus.h_len_o;
            d = stall_en ? $urandom_range(0, 10) : 0;
            for (int i = 0; i < int'(d); i++) begin
                @(negedge clk);
                check_val("req_hold_v",   512'(hbus.h_v_o), 512'(1));
                check_val("req_hold_key", hbus.h_key_o, k);
                check_val("req_hold_msg", hbus.h_msg_o, m);
                check_val("req_hold_len", 512'(hbus.h_len_o), 512'(l));
            end
            hbus.h_r_i = 1'b1;
            @(negedge clk);
            hbus.h_r_i = 1'b0;
            if (nreq < 2) begin
                msg_log[nreq] = m;
                len_log[nreq] = l;
            end
            nreq++;
            p  = hmac_ref(k, m, l);
            d  = stall_en ? $urandom_range(0, 10) : lat_fix;
            ab = 1'b0;
            for (int i = 0; i < int'(d); i++) begin
                @(negedge clk);
                if (rst_i) begin
                    ab = 1'b1;
                    break;
                end
                check_val("wait_hold_r", 512'(hbus.h_r_o), 512'(1));
            end
            if (ab) continue;
            check_val("rsp_rdy", 512'(hbus.h_r_o), 512'(1));
            hbus.h_v_i   = 1'b1;
            hbus.h_prf_i = p;
            @(negedge clk);
            hbus.h_v_i = 1'b0;
            check_val("rsp_to_next", 512'(hbus.h_v_o | v_o), 512'(1));
        end
    end

    always @(negedge clk) begin
        check_val("hv_hr_excl", 512'(hbus.h_v_o & hbus.h_r_o), 512'(0));
    end

    // ---------------------------------------------------------------------
    // Host-side helpers (called and returning on a negedge)
    // ---------------------------------------------------------------------
    task automatic start_job(input logic [407:0] salt, input logic [5:0] slen, input logic [31:0] iter);
        nreq       = 0;
        pwd_i      = PWD;
        salt_i     = salt;
        salt_len_i = slen;
        iter_i     = iter;
        v_i        = 1'b1;
        check_val("acc_rdy", 512'(r_o), 512'(1));
        @(negedge clk);
        v_i = 1'b0;
    endtask

    task automatic finish_job(input int unsigned hold, output logic [255:0] dk, output logic err);
        int unsigned n = 0;
        while (!v_o && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_val("done_seen", 512'(v_o), 512'(1));
        dk  = dk_o;
        err = err_o;
        for (int i = 0; i < int'(hold); i++) begin
            @(negedge clk);
            check_val("done_hold_v",  512'(v_o), 512'(1));
            check_val("done_hold_dk", 512'(dk_o), 512'(dk));
        end
        r_i = 1'b1;
        @(negedge clk);
        r_i = 1'b0;
        check_val("idle_back", 512'(r_o), 512'(1));
        check_val("dk_kept",   512'(dk_o), 512'(dk));
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ctl"}, 512'({r_o, v_o, err_o, hbus.h_v_o, hbus.h_r_o, hbus.h_len_o}), 512'(0));
        check_val({tag, "_dk"},  512'(dk_o), 512'(0));
        check_val({tag, "_key"}, hbus.h_key_o, 512'(0));
        check_val({tag, "_msg"}, hbus.h_msg_o, 512'(0));
    endtask

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin : main
        logic [255:0] dk;
        logic         err;
        int unsigned  n;

        rst_i = 1'b1; v_i = 1'b0; r_i = 1'b0;
        pwd_i = '0; salt_i = '0; salt_len_i = '0; iter_i = '0;
        repeat (3) @(negedge clk);
        check_all_zero("por");
        rst_i = 1'b0;
        @(negedge clk);
        check_val("por_rdy", 512'(r_o), 512'(1));

        // c = 1
        start_job(SALT4, 6'd4, 32'd1);
        check_val("c1_acc2hv", 512'(hbus.h_v_o), 512'(1));
        finish_job(0, dk, err);
        check_val("c1_dk",   512'(dk), 512'(DK1));
        check_val("c1_err",  512'(err), 512'(0));
        check_val("c1_nreq", 512'(nreq), 512'(1));
        check_val("c1_msg",  msg_log[0], MSG1);
        check_val("c1_len",  512'(len_log[0]), 512'(8));

        // c = 2
        start_job(SALT4, 6'd4, 32'd2);
        finish_job(0, dk, err);
        check_val("c2_dk",    512'(dk), 512'(DK2));
        check_val("c2_err",   512'(err), 512'(0));
        check_val("c2_nreq",  512'(nreq), 512'(2));
        check_val("c2_len2",  512'(len_log[1]), 512'(32));
        check_val("c2_msg2u", 512'(msg_log[1][511:256]), 512'(DK1));
        check_val("c2_msg2z", 512'(msg_log[1][255:0]), 512'(0));

        // c = 4096
        start_job(SALT4, 6'd4, 32'd4096);
        finish_job(0, dk, err);
        check_val("c4096_dk",   512'(dk), 512'(DK4096));
        check_val("c4096_nreq", 512'(nreq), 512'(4096));

        // Rejects: c = 0, then salt_len = 52
        start_job(SALT4, 6'd4, 32'd0);
        check_val("rej0_v",   512'(v_o), 512'(1));
        check_val("rej0_err", 512'(err_o), 512'(1));
        check_val("rej0_dk",  512'(dk_o), 512'(0));
        finish_job(0, dk, err);
        check_val("rej0_nreq", 512'(nreq), 512'(0));

        start_job(SALT4, 6'd52, 32'd1);
        check_val("rej52_v",   512'(v_o), 512'(1));
        check_val("rej52_err", 512'(err_o), 512'(1));
        check_val("rej52_dk",  512'(dk_o), 512'(0));
        finish_job(0, dk, err);
        check_val("rej52_nreq", 512'(nreq), 512'(0));

        // Largest legal salt (51 bytes)
        start_job(SALT51, 6'd51, 32'd1);
        finish_job(0, dk, err);
        check_val("s51_err", 512'(err), 512'(0));
        check_val("s51_msg", msg_log[0], MSG51);
        check_val("s51_len", 512'(len_log[0]), 512'(55));
        check_val("s51_dk",  512'(dk), 512'(hmac_ref(PWD, MSG51, 6'd55)));

        // Random stalls, junk beyond salt_len, result held 5 cycles
        stall_en = 1'b1;
        start_job(SALT4_JNK, 6'd4, 32'd2);
        finish_job(5, dk, err);
        stall_en = 1'b0;
        check_val("stall_dk",  512'(dk), 512'(DK2));
        check_val("stall_msg", msg_log[0], MSG1);

        // Reset in the middle of WAIT at c = 10
        lat_fix = 20;
        start_job(SALT4, 6'd4, 32'd10);
        n = 0;
        while (!hbus.h_r_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("mid_wait_seen", 512'(hbus.h_r_o), 512'(1));
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        #1;
        check_all_zero("mid_rst_a");
        @(negedge clk);
        check_all_zero("mid_rst_b");
        rst_i = 1'b0;
        @(negedge clk);
        check_val("mid_rel_rdy", 512'(r_o), 512'(1));
        check_val("mid_rel_v",   512'(v_o), 512'(0));
        lat_fix = 0;
        start_job(SALT4, 6'd4, 32'd1);
        finish_job(0, dk, err);
        check_val("post_rst_dk", 512'(dk), 512'(DK1));

        // Maximum count is accepted and runs; abort with reset
        lat_fix = 20;
        start_job(SALT4, 6'd4, 32'hFFFF_FFFF);
        check_val("max_acc2hv", 512'(hbus.h_v_o), 512'(1));
        n = 0;
        while (nreq < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("max_running", 512'({v_o, err_o, nreq >= 2}), 512'(1));
        rst_i = 1'b1;
        @(negedge clk);
        check_all_zero("max_rst");
        rst_i = 1'b0;
        @(negedge clk);
        check_val("max_rel_rdy", 512'(r_o), 512'(1));
        lat_fix = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
